gpmc_master: RTL and testbench
==============================

Name: gpmc_master

Overview:
- GPMC initiator that drives asynchronous, multiplexed 16-bit address/data single-word cycles, the responder-facing counterpart of the FPGA GPMC target.
- Converts a valid/ready request port into chip-select, ADV, WE, OE and BE sequences, then returns read data or a write acknowledge on a one-cycle response strobe.
- Used for FPGA-side loopback of the bridge and as the bus driver in bridge bring-up.
- The AD bus is split into out, oe and in; the top level owns the tristate pad.

Parameters:
- ADDR_CYC, 2: cycles GPMC_ADVN is held low with the address on AD; legal range 1..15.
- ACCESS_CYC, 4: cycles GPMC_WEN or GPMC_OEN is held low; legal range 1..15.
- TURN_CYC, 2: idle cycles with CSN high after each access, for bus turnaround; legal range 1..15.

Ports:
- CLK_100M  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both valid and ready are high
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  word address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_we  out  1  type of the completed transaction
- rsp_rdata  out  16  read data, valid while rsp_valid is high
- gpmc_ad_out  out  16  AD drive value
- gpmc_ad_oe  out  1  1 = drive AD
- gpmc_ad_in  in  16  AD sampled value
- gpmc_csn  out  1  chip select, active low
- gpmc_advn  out  1  address valid, active low
- gpmc_wen  out  1  write enable, active low
- gpmc_oen  out  1  output enable, active low
- gpmc_be0n  out  1  byte enable, active low
- busy  out  1  state is not IDLE

Behaviour:
- Reset is synchronous on CLK_100M. Reset values:
  - req_ready=1
  - csn, advn, wen, oen and be0n all =1
  - gpmc_ad_oe=0, gpmc_ad_out=0
  - rsp_valid=0, rsp_we=0, rsp_rdata=0
  - busy=0; state is IDLE.
- All GPMC outputs and all rsp outputs are registered.
- Accept: when req_valid and req_ready are both high in IDLE, latch req_we, req_addr and req_wdata, and move to ADDR on the next cycle. req_ready is high only in IDLE. Requests arriving while busy are held off; nothing is dropped.
- A 4-bit down-counter, loaded on every state entry, times each state.
- State IDLE: all strobes high, oe=0.
- State ADDR, lasting ADDR_CYC cycles:
  - csn=0, advn=0, be0n=0.
  - oe=1, ad_out = latched address.
- State HOLD, lasting 1 cycle:
  - advn=1, csn=0.
  - Address is still driven on AD, giving address hold past the ADV rising edge.
- State ACCESS, lasting ACCESS_CYC cycles, csn=0 and be0n=0:
  - Write: oe=1, ad_out = wdata, wen=0, oen=1.
  - Read: oe=0 (AD released), oen=0, wen=1.
  - Read capture: rsp_rdata takes gpmc_ad_in on the clock edge that ends the last ACCESS cycle, while OEN is still low.
- State TURN, lasting TURN_CYC cycles:
  - csn=1, advn=1, wen=1, oen=1, be0n=1, oe=0.
  - rsp_valid=1 for the first TURN cycle only, with rsp_we equal to the latched req_we.
  - rsp_rdata holds its last value for writes.
- After TURN, go to IDLE with req_ready=1.
- Latency, counting the accept cycle as 0:
  - rsp_valid is high in cycle ADDR_CYC+ACCESS_CYC+2 (8 with defaults).
  - The next accept is possible in cycle ADDR_CYC+ACCESS_CYC+TURN_CYC+2 (10 with defaults).
- WEN and OEN are never low in the same cycle, and are never low while ADVN is low.
- AD is never driven (oe=1) while OEN is low.
- Reset mid-transaction: the next cycle shows reset values. No rsp_valid is generated for the aborted access, and the latched request is discarded.
- Back-to-back requests: req_valid held high produces consecutive transactions. Each one is separated by exactly TURN_CYC cycles with CSN high, plus the single IDLE accept cycle.
- Parameter values outside 1..15 are a configuration error; a simulation-time assertion flags them.

Test Plan:
- Write: after reset, send req_we=1, addr=0x1234, wdata=0xBEEF. Required:
  - csn low for 7 cycles.
  - advn low for cycles 1–2 with AD=0x1234 and oe=1; cycle 3 has AD=0x1234 and advn=1.
  - wen low for cycles 4–7 with AD=0xBEEF.
  - rsp_valid=1 with rsp_we=1 in cycle 8 only.
- Read: send req_we=0, addr=0x00A5, with the model driving gpmc_ad_in=0x5A5A while OEN is low. Required:
  - oe=0 throughout ACCESS.
  - oen low for cycles 4–7.
  - rsp_rdata=0x5A5A with rsp_valid in cycle 8.
- Back-to-back: hold req_valid high for write 0x0001 then read 0x0002. Required:
  - req_ready high only in cycles 0 and 10.
  - csn high in cycles 8–10 between the two accesses.
- Reset mid-operation: assert reset in cycle 5 of a write. Required:
  - Cycle 6 shows csn=1, wen=1, oe=0, req_ready=1.
  - No rsp_valid within the following 20 cycles.
- Parameter sweep: ADDR_CYC=1, ACCESS_CYC=1, TURN_CYC=1. Required:
  - rsp_valid in cycle 4.
  - The protocol assertions (no simultaneous WEN/OEN low, no drive while OEN low) hold over 1000 random requests.

Source files
------------

// File: rtl/gpmc_master.sv
// rtl/gpmc_master.sv - GPMC initiator for async multiplexed 16-bit single-word cycles
module gpmc_master #(
  parameter int ADDR_CYC   = 2,
  parameter int ACCESS_CYC = 4,
  parameter int TURN_CYC   = 2
) (
  input  logic        CLK_100M,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [15:0] rsp_rdata,
  output logic [15:0] gpmc_ad_out,
  output logic        gpmc_ad_oe,
  input  logic [15:0] gpmc_ad_in,
  output logic        gpmc_csn,
  output logic        gpmc_advn,
  output logic        gpmc_wen,
  output logic        gpmc_oen,
  output logic        gpmc_be0n,
  output logic        busy
);

  localparam bit CFG_OK = (ADDR_CYC >= 1) && (ADDR_CYC <= 15) &&
                          (ACCESS_CYC >= 1) && (ACCESS_CYC <= 15) &&
                          (TURN_CYC >= 1) && (TURN_CYC <= 15);

  // Counter load values: a state lasting N cycles runs the counter N-1 .. 0.
  localparam logic [3:0] ADDR_LD   = 4'(ADDR_CYC - 1);
  localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYC - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);

  typedef enum logic [2:0] {IDLE, ADDR, HOLD, ACCESS, TURN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [15:0] wdata_q;

  always_ff @(posedge CLK_100M) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      wdata_q     <= 16'd0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_we      <= 1'b0;
      rsp_rdata   <= 16'd0;
      gpmc_ad_out <= 16'd0;
      gpmc_ad_oe  <= 1'b0;
      gpmc_csn    <= 1'b1;
      gpmc_advn   <= 1'b1;
      gpmc_wen    <= 1'b1;
      gpmc_oen    <= 1'b1;
      gpmc_be0n   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state       <= ADDR;
            cnt         <= ADDR_LD;
            we_q        <= req_we;
            wdata_q     <= req_wdata;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            gpmc_ad_out <= req_addr;
            gpmc_ad_oe  <= 1'b1;
            gpmc_csn    <= 1'b0;
            gpmc_advn   <= 1'b0;
            gpmc_be0n   <= 1'b0;
          end
        end
        ADDR: begin
          if (cnt == 4'd0) begin
            state     <= HOLD;
            gpmc_advn <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state <= ACCESS;
          cnt   <= ACCESS_LD;
          if (we_q) begin
            gpmc_ad_out <= wdata_q;
            gpmc_wen    <= 1'b0;
          end else begin
            gpmc_ad_oe <= 1'b0;
            gpmc_oen   <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state      <= TURN;
            cnt        <= TURN_LD;
            gpmc_csn   <= 1'b1;
            gpmc_wen   <= 1'b1;
            gpmc_oen   <= 1'b1;
            gpmc_be0n  <= 1'b1;
            gpmc_ad_oe <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_we     <= we_q;
            // Sampled on the edge that raises OEN, so the target is still driving.
            if (!we_q) rsp_rdata <= gpmc_ad_in;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        TURN: begin
          if (cnt == 4'd0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cfg_range: assert property (@(posedge CLK_100M) CFG_OK)
    else $error("gpmc_master: timing parameter outside 1..15");
  no_wen_oen: assert property (@(posedge CLK_100M) disable iff (reset) gpmc_wen || gpmc_oen);
  no_strobe_in_adv: assert property (@(posedge CLK_100M) disable iff (reset)
    gpmc_advn || (gpmc_wen && gpmc_oen));
  no_drive_in_read: assert property (@(posedge CLK_100M) disable iff (reset)
    !(gpmc_ad_oe && !gpmc_oen));

endmodule

// File: tb/tb_gpmc_master.sv
// tb/tb_gpmc_master.sv - randomized self-checking bench for gpmc_master
module tb_gpmc_master;

  logic CLK_100M = 1'b0;
  always #5 CLK_100M = ~CLK_100M;

  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [15:0] req_wdata = 16'd0;
  logic [15:0] rd_val = 16'd0;

  int errors = 0;
  int checks = 0;
  int viol = 0;
  logic [15:0] last_rd [2];

  logic        rdy_d, rv_d, rwe_d, oe_d, csn_d, advn_d, wen_d, oen_d, be_d, busy_d;
  logic [15:0] rd_d, ado_d, adi_d;
  logic        rdy_f, rv_f, rwe_f, oe_f, csn_f, advn_f, wen_f, oen_f, be_f, busy_f;
  logic [15:0] rd_f, ado_f, adi_f;
  logic        valid_d, valid_f;

  // The target model drives read data only while OEN is low; junk otherwise.
  assign adi_d   = oen_d ? ~rd_val : rd_val;
  assign adi_f   = oen_f ? ~rd_val : rd_val;
  assign valid_d = req_valid && !sel;
  assign valid_f = req_valid && sel;

  gpmc_master u_def (
    .CLK_100M(CLK_100M), .reset(reset), .req_valid(valid_d), .req_ready(rdy_d),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_d), .rsp_we(rwe_d), .rsp_rdata(rd_d),
    .gpmc_ad_out(ado_d), .gpmc_ad_oe(oe_d), .gpmc_ad_in(adi_d),
    .gpmc_csn(csn_d), .gpmc_advn(advn_d), .gpmc_wen(wen_d), .gpmc_oen(oen_d),
    .gpmc_be0n(be_d), .busy(busy_d)
  );

  gpmc_master #(.ADDR_CYC(1), .ACCESS_CYC(1), .TURN_CYC(1)) u_fast (
    .CLK_100M(CLK_100M), .reset(reset), .req_valid(valid_f), .req_ready(rdy_f),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_f), .rsp_we(rwe_f), .rsp_rdata(rd_f),
    .gpmc_ad_out(ado_f), .gpmc_ad_oe(oe_f), .gpmc_ad_in(adi_f),
    .gpmc_csn(csn_f), .gpmc_advn(advn_f), .gpmc_wen(wen_f), .gpmc_oen(oen_f),
    .gpmc_be0n(be_f), .busy(busy_f)
  );

  wire        m_rdy  = sel ? rdy_f  : rdy_d;
  wire        m_rv   = sel ? rv_f   : rv_d;
  wire        m_rwe  = sel ? rwe_f  : rwe_d;
  wire        m_oe   = sel ? oe_f   : oe_d;
  wire        m_csn  = sel ? csn_f  : csn_d;
  wire        m_advn = sel ? advn_f : advn_d;
  wire        m_wen  = sel ? wen_f  : wen_d;
  wire        m_oen  = sel ? oen_f  : oen_d;
  wire        m_be   = sel ? be_f   : be_d;
  wire        m_busy = sel ? busy_f : busy_d;
  wire [15:0] m_rd   = sel ? rd_f   : rd_d;
  wire [15:0] m_ado  = sel ? ado_f  : ado_d;

  always @(negedge CLK_100M) begin
    if (!reset) begin
      if ((!wen_d && !oen_d) || ((!wen_d || !oen_d) && !advn_d) || (oe_d && !oen_d)) viol++;
      if ((!wen_f && !oen_f) || ((!wen_f || !oen_f) && !advn_f) || (oe_f && !oen_f)) viol++;
    end
  end

  task automatic step();
    @(posedge CLK_100M);
    #1;
  endtask

  // One transaction from its accept cycle (0) up to the next possible accept cycle.
  task automatic txn(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] rdv, input bit keep, input bit nwe,
                     input logic [15:0] naddr, input logic [15:0] nwdata);
    int a, c_acc, t, n;
    bit in_addr, in_acc;
    logic [7:0] exp_v, act_v;
    logic [15:0] exp_rd;
    a = sel ? 1 : 2;
    c_acc = sel ? 1 : 4;
    t = sel ? 1 : 2;
    n = a + c_acc + t + 2;
    checks++;
    if (m_rdy !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b want 1", m_rdy);
    end
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    rd_val = rdv;
    for (int c = 1; c <= n; c++) begin
      step();
      if (c == 1) begin
        if (keep) begin
          req_we = nwe;
          req_addr = naddr;
          req_wdata = nwdata;
        end else begin
          req_valid = 1'b0;
          req_we = 1'($urandom_range(0, 1));
          req_addr = 16'($urandom);
          req_wdata = 16'($urandom);
        end
      end
      in_addr = (c <= a);
      in_acc = (c >= a + 2) && (c <= a + c_acc + 1);
      exp_v = {!(c <= a + c_acc + 1), !in_addr, !(we && in_acc), !(!we && in_acc),
               (c <= a + 1) || (we && in_acc), c == a + c_acc + 2, c == n, c < n};
      act_v = {m_csn, m_advn, m_wen, m_oen, m_oe, m_rv, m_rdy, m_busy};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL strobes cycle %0d we=%0b: got csn/advn/wen/oen/oe/rv/rdy/busy=%b want %b",
                 c, we, act_v, exp_v);
      end
      if (c != a + 1) begin
        checks++;
        if (m_be !== !(in_addr || in_acc)) begin
          errors++;
          $display("FAIL be0n cycle %0d: got %b want %b", c, m_be, !(in_addr || in_acc));
        end
      end
      if (exp_v[3]) begin
        checks++;
        if (m_ado !== ((c <= a + 1) ? addr : wdata)) begin
          errors++;
          $display("FAIL ad_out cycle %0d: got %h want %h", c, m_ado,
                   (c <= a + 1) ? addr : wdata);
        end
      end
      if (c == a + c_acc + 2) begin
        exp_rd = we ? last_rd[sel] : rdv;
        checks++;
        if (m_rwe !== we || m_rd !== exp_rd) begin
          errors++;
          $display("FAIL rsp cycle %0d: got we=%b rdata=%h want we=%b rdata=%h",
                   c, m_rwe, m_rd, we, exp_rd);
        end
        last_rd[sel] = exp_rd;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({m_rdy, m_csn, m_advn, m_wen, m_oen, m_be, m_oe, m_rv, m_rwe, m_busy} !== 10'b1111110000 ||
          m_rd !== 16'd0 || m_ado !== 16'd0) begin
        errors++;
        $display("FAIL reset_values dut%0d: got flags=%b rd=%h ad=%h want 1111110000 0 0", s,
                 {m_rdy, m_csn, m_advn, m_wen, m_oen, m_be, m_oe, m_rv, m_rwe, m_busy}, m_rd, m_ado);
      end
    end
    sel = 1'b0;
    last_rd[0] = 16'd0;
    last_rd[1] = 16'd0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_write();
    txn(1'b1, 16'h1234, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic test_read();
    txn(1'b0, 16'h00A5, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic test_back_to_back();
    txn(1'b1, 16'h0001, 16'hC0DE, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
    txn(1'b0, 16'h0002, 16'h0000, 16'h3C3C, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 16'h4321;
    req_wdata = 16'h8888;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) req_valid = 1'b0;
    end
    reset = 1'b1;
    step();
    checks++;
    if ({m_csn, m_wen, m_oe, m_rdy, m_rv} !== 5'b11010) begin
      errors++;
      $display("FAIL reset_mid_values: got csn/wen/oe/rdy/rv=%b want 11010",
               {m_csn, m_wen, m_oe, m_rdy, m_rv});
    end
    reset = 1'b0;
    last_rd[0] = 16'd0;
    last_rd[1] = 16'd0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (m_rv !== 1'b0 || m_rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle %0d: got rv=%b rdy=%b want 0 1", c, m_rv, m_rdy);
      end
    end
  endtask

  task automatic test_random(input bit s, input int count);
    bit cwe, nwe, k;
    logic [15:0] ca, cw, na, nw;
    sel = s;
    #1;
    cwe = 1'($urandom_range(0, 1));
    ca = 16'($urandom);
    cw = 16'($urandom);
    for (int i = 0; i < count; i++) begin
      nwe = 1'($urandom_range(0, 1));
      na = 16'($urandom);
      nw = 16'($urandom);
      k = 1'($urandom_range(0, 1));
      txn(cwe, ca, cw, 16'($urandom), k, nwe, na, nw);
      cwe = nwe;
      ca = na;
      cw = nw;
    end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_protocol();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL protocol_rules: got %0d violating cycles want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_random(1'b0, 100);
    test_random(1'b1, 1000);
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
